// File: rtl/fetch_if.sv
// fetch_if: ROM address/data, downstream control and IF/ID outputs of the fetch stage.
interface fetch_if #(parameter int PC_W = 16, parameter int INST_W = 9);
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] instruction;
  logic              stall;
  logic              flush;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [INST_W-1:0] if_inst;
  logic [PC_W-1:0]   if_pc;
  logic              if_valid;
  logic              halted;
  logic [15:0]       fetch_count;
  modport master (
    output pc, if_inst, if_pc, if_valid, halted, fetch_count,
    input  instruction, stall, flush, redirect, redirect_pc
  );
  modport slave (
    input  pc, if_inst, if_pc, if_valid, halted, fetch_count,
    output instruction, stall, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, IF/ID register, redirect/flush/stall handling and halt detection.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 9,
  parameter logic [PC_W-1:0] RESET_PC = 16'd1,
  parameter logic [4:0]      OPC_HALT = 5'b11010
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t            r_state, w_state_n;
  logic [PC_W-1:0]   r_pc, w_pc_n, r_if_pc, w_if_pc_n;
  logic [INST_W-1:0] r_if_inst, w_if_inst_n;
  logic              r_if_valid, w_if_valid_n;
  logic [15:0]       r_count, w_count_n;
  logic              w_is_halt;
  assign w_is_halt = bus.instruction[INST_W-1:INST_W-5] == OPC_HALT;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_if_inst  <= '0;
      r_if_valid <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_if_pc    <= w_if_pc_n;
      r_if_inst  <= w_if_inst_n;
      r_if_valid <= w_if_valid_n;
      r_count    <= w_count_n;
    end
  end
  // Priority: redirect > flush > stall > halted bubble > normal fetch.
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_if_pc_n    = r_if_pc;
    w_if_inst_n  = r_if_inst;
    w_if_valid_n = r_if_valid;
    w_count_n    = r_count;
    if (bus.redirect) begin
      w_pc_n       = bus.redirect_pc;
      w_if_pc_n    = '0;
      w_if_inst_n  = '0;
      w_if_valid_n = 1'b0;
      w_state_n    = RUN;
    end else if (bus.flush) begin
      w_if_pc_n    = '0;
      w_if_inst_n  = '0;
      w_if_valid_n = 1'b0;
      w_pc_n       = (r_state == RUN && !bus.stall) ? r_pc + 1'b1 : r_pc;
    end else if (bus.stall) begin
      w_pc_n = r_pc;
    end else if (r_state == HALTED) begin
      w_if_pc_n    = '0;
      w_if_inst_n  = '0;
      w_if_valid_n = 1'b0;
    end else begin
      w_if_inst_n  = bus.instruction;
      w_if_pc_n    = r_pc;
      w_if_valid_n = 1'b1;
      w_count_n    = (r_count == 16'hFFFF) ? r_count : r_count + 1'b1;
      w_pc_n       = w_is_halt ? r_pc : r_pc + 1'b1;
      w_state_n    = w_is_halt ? HALTED : RUN;
    end
  end
  assign bus.pc          = r_pc;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_inst     = r_if_inst;
  assign bus.if_valid    = r_if_valid;
  assign bus.halted      = r_state == HALTED;
  assign bus.fetch_count = r_count;
endmodule
